note_box_drawer: RTL and testbench
==================================

# note_box_drawer

Downstream stage of the note-to-coordinate decoder. Takes a grid cell (column 0–4 = metal bar, row 0–5) and a draw/erase request, and walks a filled rectangle inside that cell pixel by pixel. It issues one plot per clock to the 160x120 VGA adapter and hands back a done pulse to the game controller.

## Interface
Parameters:
- CELL_W, 32, cell pitch in x (pixels)
- CELL_H, 20, cell pitch in y (pixels)
- MARGIN, 2, inset of box from cell origin on both axes
- BOX_W, 28, box width (pixels)
- BOX_H, 16, box height (pixels)

Ports:
- clk  in  1  system clock; one clock domain, all logic on rising edge
- reset  in  1  synchronous, active-high
- req  in  1  start request, sampled only in IDLE
- erase  in  1  sampled with req; 1 = draw black, 0 = draw column colour
- grid_x  in  3  cell column, valid 0–4, sampled with req
- grid_y  in  3  cell row, valid 0–5, sampled with req
- vga_x  out  8  pixel x to VGA adapter
- vga_y  out  7  pixel y to VGA adapter
- colour  out  3  RGB pixel colour
- plot  out  1  write strobe, one pixel per high cycle
- busy  out  1  high while a box is in progress
- done  out  1  one-cycle pulse after the last pixel
- err  out  1  one-cycle pulse on rejected request

## Operation
States: IDLE, DRAW, DONE.

IDLE
- When req=1, the block latches grid_x, grid_y and erase.
- If grid_x>4 or grid_y>5: stay in IDLE and pulse err the next cycle. No plot occurs.
- Otherwise: clear the counters cx=0, cy=0 and go to DRAW.

DRAW
- Each cycle: plot=1, vga_x = grid_x*CELL_W + MARGIN + cx, vga_y = grid_y*CELL_H + MARGIN + cy.
- Scan order is row-major: cx increments 0..BOX_W-1. At wrap, cx returns to 0 and cy increments.
- After the pixel at cx=BOX_W-1, cy=BOX_H-1, go to DONE.

DONE
- plot=0, done=1 for one cycle, then go to IDLE.

Colour
- erase=1: colour=000.
- erase=0: colour by latched grid_x: 0→100, 1→110, 2→010, 3→011, 4→001.

Widths and constraints
- cx is 5 bits, cy is 4 bits.
- Address arithmetic is unsigned. Maximum vga_x=157 and maximum vga_y=117, so there is no overflow.

Requests and reset
- req in DRAW or DONE is ignored; it is not queued. Changes to grid_x, grid_y or erase after acceptance have no effect.
- reset in any state: the next state is IDLE and all counters clear.

Outputs
- All outputs are registered.
- Reset values: vga_x=0, vga_y=0, colour=000, plot=0, busy=0, done=0, err=0.

## Timing
- Accepted req at edge T: first plotted pixel is presented T+1, last pixel T+BOX_W*BOX_H (T+448 with defaults).
- done is high at T+449. The block is back in IDLE at T+450, and a new req may be accepted at that edge.
- busy is high T+1 through T+449 inclusive. plot is high exactly 448 consecutive cycles.
- Rejected req at T: err=1 at T+1 only. busy stays 0.
- Reset asserted at edge R: at R+1 plot=0, busy=0, done=0. A req held high with reset is ignored.
- A req at T+450 while done has just dropped is accepted normally, giving back-to-back boxes with a 2-cycle gap in plot.

## Test plan
- req, grid (0,0), erase=0 -> 448 plots; first (2,2), last (29,17); colour=100 throughout; done one cycle after the last pixel.
- req, grid (4,5), erase=0 -> first (130,102), 28th pixel (157,102), 29th (130,103), last (157,117); colour=001.
- req, grid (2,3), erase=1 -> pixels x 66..93, y 62..77; colour=000; count=448.
- req, grid (5,0) and separately (0,6) -> err pulse exactly one cycle; plot, busy and done stay 0.
- req, grid (1,1); pulse req with grid (3,3) mid-draw -> all 448 pixels remain in cell (1,1) (x 34..61, y 22..37); no second box.
- Start a box, assert reset at pixel 100 -> plot=0 next cycle, no done pulse; a subsequent req draws a full 448-pixel box from the first pixel.

Source files
------------

// File: rtl/note_box_drawer.sv
// note_box_drawer: walks a filled BOX_W x BOX_H rectangle inside one grid
// cell, emitting one VGA plot per clock, then pulses done. Requests with an
// out-of-range cell are rejected with a one-cycle err pulse.
//
// Pipeline shape: the FSM and scan counters form the first stage, and every
// output is a register fed from that stage. A request accepted at edge T moves
// the FSM to DRAW at T; the first pixel appears on the outputs at T+1 and the
// last one at T+BOX_W*BOX_H. done follows one cycle later, and the FSM is back
// in IDLE in time to accept a new request on the edge after done rises.
module note_box_drawer #(
    parameter int CELL_W = 32,
    parameter int CELL_H = 20,
    parameter int MARGIN = 2,
    parameter int BOX_W  = 28,
    parameter int BOX_H  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       erase,
    input  logic [2:0] grid_x,
    input  logic [2:0] grid_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // Highest legal cell coordinates (5 metal-bar columns, 6 rows).
    localparam logic [2:0] GRID_X_MAX = 3'd4;
    localparam logic [2:0] GRID_Y_MAX = 3'd5;

    // Scan counter limits, sized to the 5-bit cx and 4-bit cy counters.
    localparam logic [4:0] CX_LAST = 5'(BOX_W - 1);
    localparam logic [3:0] CY_LAST = 4'(BOX_H - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_d;

    // Request fields captured on acceptance; later input changes are ignored.
    logic [2:0] gx_q;
    logic [2:0] gy_q;
    logic       erase_q;

    // Position of the next pixel inside the box.
    logic [4:0] cx;
    logic [3:0] cy;

    // A rejected request was seen; err is raised from this on the next edge.
    logic       rej_q;

    logic       grid_ok;
    logic       accept;
    logic       reject;
    logic       last_px;
    logic [7:0] px_x;
    logic [6:0] px_y;
    logic [2:0] px_colour;

    // Colour of a box: black when erasing, otherwise the column's bar colour.
    function automatic logic [2:0] column_colour(input logic [2:0] col,
                                                 input logic       blank);
        logic [2:0] c;
        c = 3'b000;
        if (!blank) begin
            case (col)
                3'd0:    c = 3'b100;
                3'd1:    c = 3'b110;
                3'd2:    c = 3'b010;
                3'd3:    c = 3'b011;
                3'd4:    c = 3'b001;
                default: c = 3'b000;
            endcase
        end
        return c;
    endfunction

    assign grid_ok = (grid_x <= GRID_X_MAX) && (grid_y <= GRID_Y_MAX);
    assign accept  = (state == IDLE) && req && grid_ok;
    assign reject  = (state == IDLE) && req && !grid_ok;
    assign last_px = (cx == CX_LAST) && (cy == CY_LAST);

    // Pixel address of the current scan position. Maximum is (157,117) with
    // the default geometry, so the 8/7-bit truncation never drops a carry.
    assign px_x      = 8'(int'(gx_q) * CELL_W + MARGIN + int'(cx));
    assign px_y      = 7'(int'(gy_q) * CELL_H + MARGIN + int'(cy));
    assign px_colour = column_colour(gx_q, erase_q);

    // Next-state logic for the IDLE -> DRAW -> DONE walk.
    always_comb begin
        // NOTE: state_d gets a default before the case so no path leaves it
        // unassigned; without it synthesis would infer a latch.
        state_d = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (last_px) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset wins over any request presented on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Capture the request fields and flag rejections while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            gx_q    <= 3'd0;
            gy_q    <= 3'd0;
            erase_q <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            rej_q <= reject;
            if (accept) begin
                gx_q    <= grid_x;
                gy_q    <= grid_y;
                erase_q <= erase;
            end
        end
    end

    // Row-major scan counters: cx sweeps the row, cy steps at each wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cx <= 5'd0;
            cy <= 4'd0;
        end else if (accept) begin
            cx <= 5'd0;
            cy <= 4'd0;
        end else if (state == DRAW) begin
            if (cx == CX_LAST) begin
                cx <= 5'd0;
                cy <= cy + 4'd1;
            end else begin
                cx <= cx + 5'd1;
            end
        end
    end

    // Registered outputs, one stage behind the FSM and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_x  <= 8'd0;
            vga_y  <= 7'd0;
            colour <= 3'b000;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            plot <= (state == DRAW);
            busy <= (state != IDLE);
            done <= (state == DONE);
            err  <= rej_q;
            if (state == DRAW) begin
                vga_x  <= px_x;
                vga_y  <= px_y;
                colour <= px_colour;
            end
        end
    end

endmodule

// File: tb/tb_note_box_drawer.sv
// Scoreboard bench for note_box_drawer: the driver pushes every expected pixel
// of a box into a queue, and a monitor pops and compares on each plot cycle.
module tb_note_box_drawer;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic       clk;
    logic       reset;
    logic       req;
    logic       erase;
    logic [2:0] grid_x;
    logic [2:0] grid_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;
    logic       err;

    int   tests     = 0;
    int   failed    = 0;
    int   pix_seen  = 0;
    int   done_seen = 0;
    int   low_run   = 0;
    bit   gap_check = 0;
    pix_t exp_q[$];
    pix_t mon_e;

    note_box_drawer dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .erase  (erase),
        .grid_x (grid_x),
        .grid_y (grid_y),
        .vga_x  (vga_x),
        .vga_y  (vga_y),
        .colour (colour),
        .plot   (plot),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Hand-written column colour table.
    function automatic logic [2:0] exp_colour(input int gx, input bit er);
        if (er) return 3'b000;
        case (gx)
            0: return 3'b100;
            1: return 3'b110;
            2: return 3'b010;
            3: return 3'b011;
            default: return 3'b001;
        endcase
    endfunction

    // Expected pixel stream of one box in row-major order.
    task automatic push_box(input int gx, input int gy, input bit er);
        pix_t p;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 28; x++) begin
                p.x = 8'(gx * 32 + 2 + x);
                p.y = 7'(gy * 20 + 2 + y);
                p.c = exp_colour(gx, er);
                exp_q.push_back(p);
            end
        end
    endtask

    // Present a request (caller is at a negedge) across one rising edge.
    task automatic issue_req(input int gx, input int gy, input bit er);
        grid_x = 3'(gx);
        grid_y = 3'(gy);
        erase  = er;
        req    = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic start_box(input int gx, input int gy, input bit er);
        @(negedge clk);
        push_box(gx, gy, er);
        issue_req(gx, gy, er);
    endtask

    // Count negedges until done is seen; bounded.
    task automatic wait_done(output int cycles);
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (done) break;
            if (cycles > 700) begin
                check("done_timeout", 0, 1);
                break;
            end
        end
    endtask

    // After done: single-cycle pulse, busy drops, scoreboard drained.
    task automatic check_done_tail(input string tag);
        check({tag, "_busy_at_done"}, busy, 1);
        check({tag, "_plot_at_done"}, plot, 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // Monitor: compare every plotted pixel against the scoreboard head.
    always @(negedge clk) begin
        if (done) done_seen++;
        if (plot) begin
            pix_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_plot", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pix_x", int'(vga_x), int'(mon_e.x));
                check("pix_y", int'(vga_y), int'(mon_e.y));
                check("pix_colour", int'(colour), int'(mon_e.c));
            end
            if (gap_check) begin
                check("b2b_plot_gap", low_run, 2);
                gap_check = 0;
            end
            low_run = 0;
        end else begin
            low_run++;
        end
    end

    initial begin
        int cyc;
        int base;
        int dbase;

        reset  = 1'b1;
        req    = 1'b0;
        erase  = 1'b0;
        grid_x = 3'd0;
        grid_y = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_vga_x", vga_x, 0);
        check("rst_vga_y", vga_y, 0);
        check("rst_colour", colour, 0);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset = 1'b0;

        // Box in cell (0,0), column colour.
        base = pix_seen;
        start_box(0, 0, 0);
        wait_done(cyc);
        check("b00_done_latency", cyc, 450);
        check_done_tail("b00");
        check("b00_pixel_count", pix_seen - base, 448);

        // Box in cell (4,5): extreme addresses (157,117).
        base = pix_seen;
        start_box(4, 5, 0);
        wait_done(cyc);
        check("b45_done_latency", cyc, 450);
        check_done_tail("b45");
        check("b45_pixel_count", pix_seen - base, 448);

        // Erase box in cell (2,3), then a back-to-back box right at done.
        base = pix_seen;
        start_box(2, 3, 1);
        wait_done(cyc);
        check("b23_done_latency", cyc, 450);
        check("b23_pixel_count", pix_seen - base, 448);
        gap_check = 1;
        base = pix_seen;
        push_box(3, 2, 0);
        issue_req(3, 2, 0);
        wait_done(cyc);
        check("b2b_done_latency", cyc, 450);
        check_done_tail("b2b");
        check("b2b_pixel_count", pix_seen - base, 448);
        check("b2b_gap_seen", int'(gap_check), 0);

        // Rejected requests: err for exactly one cycle, nothing else moves.
        for (int k = 0; k < 2; k++) begin
            dbase = done_seen;
            base  = pix_seen;
            @(negedge clk);
            issue_req(k == 0 ? 5 : 0, k == 0 ? 0 : 6, 0);
            @(negedge clk);
            check("rej_err_t0", err, 0);
            @(negedge clk);
            check("rej_err_t1", err, 1);
            check("rej_busy_t1", busy, 0);
            @(negedge clk);
            check("rej_err_t2", err, 0);
            repeat (3) begin
                @(negedge clk);
                check("rej_busy", busy, 0);
            end
            check("rej_no_plot", pix_seen - base, 0);
            check("rej_no_done", done_seen - dbase, 0);
        end

        // Request with another cell mid-draw is ignored.
        base = pix_seen;
        start_box(1, 1, 0);
        repeat (50) @(negedge clk);
        issue_req(3, 3, 1);
        wait_done(cyc);
        check_done_tail("mid");
        repeat (20) @(negedge clk);
        check("mid_pixel_count", pix_seen - base, 448);
        check("mid_idle_busy", busy, 0);

        // Reset in the middle of a box, then a full box afterwards.
        base  = pix_seen;
        dbase = done_seen;
        start_box(0, 2, 0);
        cyc = 0;
        while (pix_seen - base < 100 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reached_px100", pix_seen - base, 100);
        reset = 1'b1;
        req   = 1'b1;
        @(negedge clk);
        check("midrst_plot", plot, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        req   = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("postrst_idle_plot", plot, 0);
        end
        check("postrst_no_done", done_seen - dbase, 0);
        base = pix_seen;
        start_box(2, 4, 0);
        wait_done(cyc);
        check("postrst_done_latency", cyc, 450);
        check_done_tail("postrst");
        check("postrst_pixel_count", pix_seen - base, 448);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
